// File: rtl/fpu_issue_scheduler.sv
// rtl/fpu_issue_scheduler.sv - issue sequencer for the two VLIW FPU lanes sharing one fdiv/fsqrt unit
// One FSM replaces the per-lane stall counters; the bundle latency T is latched on entry to RUN.
module fpu_issue_scheduler #(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 5,
  parameter int LAT_SQRT = 2,
  parameter int LAT_CVT  = 1,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid1,
  input  logic [4:0]  op1,
  input  logic        valid2,
  input  logic [4:0]  op2,
  input  logic        flush,
  output logic        stall,
  output logic        div_start,
  output logic        div_lane,
  output logic        done1,
  output logic        done2,
  output logic        keep_rd,
  output logic        fstalled,
  output logic [31:0] perf_stall
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Returns {div_class, latency}; an invalid slot contributes nothing.
  function automatic logic [CNT_W:0] decode(input logic v, input logic [4:0] op);
    logic [CNT_W:0] r;
    r = '0;
    if (v) begin
      case (op)
        5'b00001, 5'b00011: r = {1'b0, CNT_W'(LAT_ADD)};
        5'b00101:           r = {1'b0, CNT_W'(LAT_MUL)};
        5'b00111:           r = {1'b1, CNT_W'(LAT_DIV)};
        5'b01101:           r = {1'b1, CNT_W'(LAT_SQRT)};
        5'b10001, 5'b10011: r = {1'b0, CNT_W'(LAT_CVT)};
        default:            r = '0;
      endcase
    end
    return r;
  endfunction

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] t_q;
  logic [CNT_W-1:0] l1_q;
  logic [CNT_W-1:0] l2_q;
  logic             ser_q;
  logic             div_lane_q;
  logic             fstalled_q;
  logic [31:0]      perf_q;

  logic [CNT_W:0]   dec1;
  logic [CNT_W:0]   dec2;
  logic [CNT_W-1:0] l1;
  logic [CNT_W-1:0] l2;
  logic             d1;
  logic             d2;
  logic             ser_now;
  logic [CNT_W-1:0] t_now;
  logic             idle_go;
  logic             lane_new;
  logic             active;

  always_comb begin
    dec1    = decode(valid1, op1);
    dec2    = decode(valid2, op2);
    l1      = dec1[CNT_W-1:0];
    d1      = dec1[CNT_W];
    l2      = dec2[CNT_W-1:0];
    d2      = dec2[CNT_W];
    ser_now = d1 && d2;
    if (ser_now)
      t_now = l1 + l2;
    else
      t_now = (l1 > l2) ? l1 : l2;
    idle_go = (state == S_IDLE) && (t_now != '0);
  end

  // Reset and flush both silence every combinational strobe in the same cycle.
  always_comb begin
    active    = !rst && !flush;
    stall     = 1'b0;
    keep_rd   = 1'b0;
    div_start = 1'b0;
    done1     = 1'b0;
    done2     = 1'b0;
    lane_new  = div_lane_q;
    if (state == S_IDLE) begin
      stall     = active && idle_go;
      keep_rd   = active && idle_go;
      div_start = active && (d1 || d2);
      lane_new  = !d1;
    end else begin
      stall     = active && (cnt != t_q);
      done1     = active && (cnt == l1_q);
      done2     = active && (ser_q ? (cnt == t_q) : (cnt == l2_q));
      div_start = active && ser_q && (cnt == l1_q);
      lane_new  = 1'b1;
    end
  end

  assign div_lane   = div_start ? lane_new : div_lane_q;
  assign fstalled   = fstalled_q;
  assign perf_stall = perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      t_q        <= '0;
      l1_q       <= '0;
      l2_q       <= '0;
      ser_q      <= 1'b0;
      div_lane_q <= 1'b0;
      fstalled_q <= 1'b0;
      perf_q     <= '0;
    end else begin
      fstalled_q <= stall;
      if (stall && (perf_q != 32'hFFFF_FFFF))
        perf_q <= perf_q + 32'd1;
      if (div_start)
        div_lane_q <= lane_new;
      if (flush) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (idle_go) begin
              state <= S_RUN;
              cnt   <= CNT_W'(1);
              t_q   <= t_now;
              l1_q  <= l1;
              l2_q  <= l2;
              ser_q <= ser_now;
            end
          end
          default: begin
            if (cnt == t_q) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule
